// File: rtl/sopc_onchip_ram_dp.sv
// True dual-port on-chip RAM with per-lane byte enables, a pipelined read
// path of latency 1 or 2 and a saturating counter of overlapping dual writes.
module sopc_onchip_ram_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 51200,
  parameter int OUT_REG    = 0,
  parameter     INIT_FILE  = "sopc_onchip_ram_dp.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,

  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,

  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,

  output logic [7:0]              collision_cnt
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic             en;
  logic             s1_acc, s2_acc;
  logic             s1_ok, s2_ok;
  logic             s1_wr, s2_wr;
  logic             s1_rd, s2_rd;
  logic [IDX_W-1:0] s1_idx, s2_idx;
  logic             collide;

  assign en             = clken & ~reset_req;
  assign s1_waitrequest = ~en;
  assign s2_waitrequest = ~en;

  assign s1_acc = s1_chipselect & (s1_read | s1_write) & en;
  assign s2_acc = s2_chipselect & (s2_read | s2_write) & en;

  assign s1_ok  = {1'b0, s1_address} < DEPTH_L;
  assign s2_ok  = {1'b0, s2_address} < DEPTH_L;
  assign s1_idx = s1_address[IDX_W-1:0];
  assign s2_idx = s2_address[IDX_W-1:0];

  // A read strobe alongside a write strobe is a pure write.
  assign s1_wr = s1_acc & s1_write & s1_ok & ~reset;
  assign s2_wr = s2_acc & s2_write & s2_ok & ~reset;
  assign s1_rd = s1_acc & ~s1_write & ~reset;
  assign s2_rd = s2_acc & ~s2_write & ~reset;

  assign collide = s1_wr & s2_wr & (s1_address == s2_address) &
                   (|(s1_byteenable & s2_byteenable));

  // s1 is applied last so it owns any lane both ports write to one word.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (s2_wr && s2_byteenable[b]) mem[s2_idx][b*8 +: 8] <= s2_writedata[b*8 +: 8];
      if (s1_wr && s1_byteenable[b]) mem[s1_idx][b*8 +: 8] <= s1_writedata[b*8 +: 8];
    end
  end

  logic                  s1_v1, s2_v1;
  logic [DATA_WIDTH-1:0] s1_d1, s2_d1;

  // Array reads sample pre-edge contents, so a same-cycle write yields old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v1 <= 1'b0;
      s2_v1 <= 1'b0;
      s1_d1 <= '0;
      s2_d1 <= '0;
    end else begin
      s1_v1 <= s1_rd;
      s2_v1 <= s2_rd;
      if (s1_rd) s1_d1 <= s1_ok ? mem[s1_idx] : '0;
      if (s2_rd) s2_d1 <= s2_ok ? mem[s2_idx] : '0;
    end
  end

  logic                  s1_vq, s2_vq;
  logic [DATA_WIDTH-1:0] s1_dq, s2_dq;

  if (OUT_REG != 0) begin : g_out_reg
    logic                  s1_v2, s2_v2;
    logic [DATA_WIDTH-1:0] s1_d2, s2_d2;

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_v2 <= 1'b0;
        s2_v2 <= 1'b0;
        s1_d2 <= '0;
        s2_d2 <= '0;
      end else begin
        s1_v2 <= s1_v1;
        s2_v2 <= s2_v1;
        if (s1_v1) s1_d2 <= s1_d1;
        if (s2_v1) s2_d2 <= s2_d1;
      end
    end

    assign s1_vq = s1_v2;
    assign s2_vq = s2_v2;
    assign s1_dq = s1_d2;
    assign s2_dq = s2_d2;
  end else begin : g_no_out_reg
    assign s1_vq = s1_v1;
    assign s2_vq = s2_v1;
    assign s1_dq = s1_d1;
    assign s2_dq = s2_d1;
  end

  // Masking with reset keeps a read already in the last stage from escaping.
  assign s1_readdatavalid = s1_vq & ~reset;
  assign s2_readdatavalid = s2_vq & ~reset;
  assign s1_readdata      = reset ? '0 : s1_dq;
  assign s2_readdata      = reset ? '0 : s2_dq;

  always_ff @(posedge clk) begin
    if (reset) begin
      collision_cnt <= 8'd0;
    end else if (collide && collision_cnt != 8'hFF) begin
      collision_cnt <= collision_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_sopc_onchip_ram_dp.sv
// Drives two RAM instances (latency 1 and latency 2) with identical stimulus;
// a negedge monitor pops expected read data per port and checks data and timing.
module tb_sopc_onchip_ram_dp;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int DP = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, clken, reset_req;
  logic [AW-1:0] s1_address, s2_address;
  logic [3:0]    s1_byteenable, s2_byteenable;
  logic          s1_chipselect, s1_read, s1_write;
  logic          s2_chipselect, s2_read, s2_write;
  logic [DW-1:0] s1_writedata, s2_writedata;

  logic [DW-1:0] a_s1_rd, a_s2_rd, b_s1_rd, b_s2_rd;
  logic          a_s1_v, a_s2_v, b_s1_v, b_s2_v;
  logic          a_s1_w, a_s2_w, b_s1_w, b_s2_w;
  logic [7:0]    a_cnt, b_cnt;

  sopc_onchip_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP), .OUT_REG(0), .INIT_FILE("")) u_lat1 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(a_s1_rd), .s1_readdatavalid(a_s1_v), .s1_waitrequest(a_s1_w),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(a_s2_rd), .s2_readdatavalid(a_s2_v), .s2_waitrequest(a_s2_w),
    .collision_cnt(a_cnt)
  );

  sopc_onchip_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP), .OUT_REG(1), .INIT_FILE("")) u_lat2 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(b_s1_rd), .s1_readdatavalid(b_s1_v), .s1_waitrequest(b_s1_w),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(b_s2_rd), .s2_readdatavalid(b_s2_v), .s2_waitrequest(b_s2_w),
    .collision_cnt(b_cnt)
  );

  // index k: 0 = lat1 s1, 1 = lat1 s2, 2 = lat2 s1, 3 = lat2 s2
  logic [DW-1:0] rdat [4];
  logic          rv   [4];
  assign rdat[0] = a_s1_rd;  assign rv[0] = a_s1_v;
  assign rdat[1] = a_s2_rd;  assign rv[1] = a_s2_v;
  assign rdat[2] = b_s1_rd;  assign rv[2] = b_s1_v;
  assign rdat[3] = b_s2_rd;  assign rv[3] = b_s2_v;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  typedef struct {
    logic          cs, rd, wr, chk;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wdata, exp;
  } cmd_t;

  exp_t q [4][$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rv[k] === 1'b1) begin
        tests++;
        if (q[k].size() == 0) begin
          fails++;
          $display("FAIL spurious_valid port%0d actual data=%h at cycle %0d, required no valid", k, rdat[k], cyc);
        end else begin
          exp_t e;
          e = q[k].pop_front();
          if (rdat[k] !== e.data || cyc != e.cyc) begin
            fails++;
            $display("FAIL readdata port%0d actual=%h@cyc%0d required=%h@cyc%0d", k, rdat[k], cyc, e.data, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic cmd_t c_nop();
    cmd_t c;
    c.cs = 1'b0; c.rd = 1'b0; c.wr = 1'b0; c.chk = 1'b0;
    c.addr = '0; c.be = '0; c.wdata = '0; c.exp = '0;
    return c;
  endfunction

  function automatic cmd_t c_rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    cmd_t c;
    c = c_nop();
    c.cs = 1'b1; c.rd = 1'b1; c.chk = 1'b1; c.addr = a; c.exp = e;
    return c;
  endfunction

  function automatic cmd_t c_wr(input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
    cmd_t c;
    c = c_nop();
    c.cs = 1'b1; c.wr = 1'b1; c.addr = a; c.be = be; c.wdata = d;
    return c;
  endfunction

  task automatic push_exp(input cmd_t c, input int k0);
    if (c.cs && c.rd && !c.wr && c.chk && clken && !reset_req && !reset) begin
      q[k0].push_back('{c.exp, cyc + 1});
      q[k0 + 2].push_back('{c.exp, cyc + 2});
    end
  endtask

  // Called one time unit after a rising edge; returns one unit after the next.
  task automatic apply(input cmd_t a, input cmd_t b);
    s1_chipselect = a.cs; s1_read = a.rd; s1_write = a.wr;
    s1_address = a.addr; s1_byteenable = a.be; s1_writedata = a.wdata;
    s2_chipselect = b.cs; s2_read = b.rd; s2_write = b.wr;
    s2_address = b.addr; s2_byteenable = b.be; s2_writedata = b.wdata;
    push_exp(a, 0);
    push_exp(b, 1);
    @(posedge clk);
    #1;
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
  endtask

  task automatic check_cnt(input string name, input logic [7:0] exp);
    check({name, "_lat1"}, {24'd0, a_cnt}, {24'd0, exp});
    check({name, "_lat2"}, {24'd0, b_cnt}, {24'd0, exp});
  endtask

  task automatic check_reset_outputs(input string name);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_rdata%0d", name, k), rdat[k], 32'h0);
      check($sformatf("%s_valid%0d", name, k), {31'd0, rv[k]}, 32'h0);
    end
    check_cnt({name, "_cnt"}, 8'd0);
  endtask

  cmd_t c, c2;

  initial begin
    reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
    s1_address = '0; s2_address = '0; s1_byteenable = '0; s2_byteenable = '0;
    s1_writedata = '0; s2_writedata = '0;
    @(posedge clk); #1;
    apply(c_nop(), c_nop());
    apply(c_nop(), c_nop());
    check_reset_outputs("reset");
    check("wait_reset_en", {30'd0, a_s1_w, b_s2_w}, 32'h0);
    reset_req = 1'b1; #1;
    check("wait_reset_req", {30'd0, a_s2_w, b_s1_w}, 32'h3);
    reset_req = 1'b0;
    reset = 1'b0;

    // write then read back
    apply(c_wr(16'h0010, 4'hF, 32'hDEADBEEF), c_nop());
    apply(c_rd(16'h0010, 32'hDEADBEEF), c_nop());

    // fill 0..3 from both ports at once, then back-to-back s2 reads
    apply(c_wr(16'h0000, 4'hF, 32'h1000_0000), c_wr(16'h0001, 4'hF, 32'h1111_0001));
    apply(c_wr(16'h0002, 4'hF, 32'h2222_0002), c_wr(16'h0003, 4'hF, 32'h3333_0003));
    check_cnt("cnt_diff_addr", 8'd0);
    apply(c_nop(), c_rd(16'h0000, 32'h1000_0000));
    apply(c_nop(), c_rd(16'h0001, 32'h1111_0001));
    apply(c_nop(), c_rd(16'h0002, 32'h2222_0002));
    apply(c_nop(), c_rd(16'h0003, 32'h3333_0003));

    // dual-write merge with overlapping lane, then with disjoint lanes
    apply(c_wr(16'h0020, 4'hF, 32'h1122_3344), c_nop());
    apply(c_wr(16'h0020, 4'h3, 32'hAAAA_AAAA), c_wr(16'h0020, 4'h6, 32'hBBBB_BBBB));
    check_cnt("cnt_overlap", 8'd1);
    apply(c_rd(16'h0020, 32'h11BB_AAAA), c_nop());
    apply(c_wr(16'h0020, 4'h1, 32'hCCCC_CCCC), c_wr(16'h0020, 4'h8, 32'hDDDD_DDDD));
    check_cnt("cnt_disjoint", 8'd1);
    apply(c_nop(), c_rd(16'h0020, 32'hDDBB_AACC));

    // read during same-address write on the other port returns old data
    apply(c_wr(16'h0030, 4'hF, 32'h0), c_nop());
    apply(c_rd(16'h0030, 32'h0), c_wr(16'h0030, 4'hF, 32'h5555_5555));
    apply(c_rd(16'h0030, 32'h5555_5555), c_nop());
    apply(c_wr(16'h0030, 4'hF, 32'h6666_6666), c_rd(16'h0030, 32'h5555_5555));
    apply(c_nop(), c_rd(16'h0030, 32'h6666_6666));

    // read+write together is a write with no valid
    c = c_wr(16'h0034, 4'hF, 32'h7777_7777); c.rd = 1'b1;
    apply(c, c_nop());
    apply(c_rd(16'h0034, 32'h7777_7777), c_nop());
    c = c_wr(16'h0034, 4'hF, 32'h1212_1212); c.rd = 1'b1;
    apply(c_nop(), c);
    apply(c_nop(), c_rd(16'h0034, 32'h1212_1212));

    // ignored: chipselect low, clken low
    c = c_wr(16'h0034, 4'hF, 32'h0); c.cs = 1'b0;
    apply(c_nop(), c);
    apply(c_rd(16'h0034, 32'h1212_1212), c_nop());
    clken = 1'b0; #1;
    check("wait_clken", {30'd0, a_s1_w, b_s2_w}, 32'h3);
    apply(c_wr(16'h0010, 4'hF, 32'h0), c_nop());
    clken = 1'b1;

    // inhibited read held for three cycles, accepted after release
    reset_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("wait_inhibit%0d", i), {28'd0, a_s1_w, a_s2_w, b_s1_w, b_s2_w}, 32'hF);
      apply(c_rd(16'h0010, 32'hDEADBEEF), c_nop());
    end
    reset_req = 1'b0; #1;
    check("wait_release", {28'd0, a_s1_w, a_s2_w, b_s1_w, b_s2_w}, 32'h0);
    apply(c_rd(16'h0010, 32'hDEADBEEF), c_nop());

    // collision counter saturation
    for (int i = 0; i < 254; i++)
      apply(c_wr(16'h0050, 4'hF, 32'(i)), c_wr(16'h0050, 4'hF, 32'(~i)));
    check_cnt("cnt_255", 8'd255);
    for (int i = 0; i < 3; i++)
      apply(c_wr(16'h0050, 4'h1, 32'h0), c_wr(16'h0050, 4'h1, 32'h1));
    check_cnt("cnt_sat", 8'd255);

    // out-of-range accesses
    apply(c_wr(16'd1023, 4'hF, 32'h0BAD_C0DE), c_nop());
    apply(c_nop(), c_wr(16'd1024, 4'hF, 32'hFFFF_FFFF));
    apply(c_wr(16'd1024, 4'hF, 32'hEEEE_EEEE), c_nop());
    apply(c_rd(16'd1023, 32'h0BAD_C0DE), c_rd(16'd1024, 32'h0));
    apply(c_rd(16'd1024, 32'h0), c_rd(16'h0000, 32'h1000_0000));

    // reads in flight when reset asserts must vanish; reset must not write
    apply(c_wr(16'h0040, 4'hF, 32'hCAFE_F00D), c_nop());
    repeat (3) apply(c_nop(), c_nop());
    c = c_rd(16'd1024, 32'h0); c.chk = 1'b0;
    c2 = c_rd(16'h0010, 32'h0); c2.chk = 1'b0;
    apply(c, c2);
    reset = 1'b1;
    apply(c_wr(16'h0040, 4'hF, 32'h1234_5678), c_nop());
    check_reset_outputs("reset_mid");
    apply(c_nop(), c_nop());
    reset = 1'b0;
    apply(c_nop(), c_rd(16'h0040, 32'hCAFE_F00D));

    repeat (4) apply(c_nop(), c_nop());
    for (int k = 0; k < 4; k++)
      check($sformatf("queue_empty%0d", k), q[k].size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
